// File: rtl/vector_check_engine.sv
// Self-check engine: replays stored stimulus/answer pairs into a fixed-latency DUT
// and scores the masked responses (pass count, fail count, first failing index).
module vector_check_engine #(
  parameter int unsigned IN_W  = 68,
  parameter int unsigned OUT_W = 34,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LAT   = 0,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [IN_W-1:0]  ld_stim,
  input  logic [OUT_W-1:0] ld_ans,
  input  logic [CW-1:0]    num_tests,
  input  logic [OUT_W-1:0] cmp_mask,
  input  logic             start,
  output logic [IN_W-1:0]  dut_stim,
  input  logic [OUT_W-1:0] dut_resp,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    score,
  output logic [CW-1:0]    err_count,
  output logic [AW-1:0]    first_err_idx,
  output logic             first_err_vld
);

  localparam int unsigned LCW = $clog2(LAT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  logic [IN_W-1:0]  mem_stim [DEPTH];
  logic [OUT_W-1:0] mem_ans  [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    n_q, n_d;
  logic [OUT_W-1:0] mask_q, mask_d;
  logic [LCW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]    score_q, score_d;
  logic [CW-1:0]    err_q, err_d;
  logic [AW-1:0]    ferr_idx_q, ferr_idx_d;
  logic             ferr_vld_q, ferr_vld_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             start_ok;
  logic [CW-1:0]    n_start;
  logic             cmp_pass;
  logic             last_vec;

  // Vector memory: no reset, frozen while a run is in progress
  always_ff @(posedge clk) begin
    if (ld_en && !busy_q) begin
      mem_stim[ld_addr] <= ld_stim;
      mem_ans[ld_addr]  <= ld_ans;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      mask_q     <= '0;
      wcnt_q     <= '0;
      score_q    <= '0;
      err_q      <= '0;
      ferr_idx_q <= '0;
      ferr_vld_q <= 1'b0;
      stim_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      mask_q     <= mask_d;
      wcnt_q     <= wcnt_d;
      score_q    <= score_d;
      err_q      <= err_d;
      ferr_idx_q <= ferr_idx_d;
      ferr_vld_q <= ferr_vld_d;
      stim_q     <= stim_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    mask_d     = mask_q;
    wcnt_d     = wcnt_q;
    score_d    = score_q;
    err_d      = err_q;
    ferr_idx_d = ferr_idx_q;
    ferr_vld_d = ferr_vld_q;
    stim_d     = stim_q;

    start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    n_start  = (num_tests > CW'(DEPTH)) ? CW'(DEPTH) : num_tests;
    cmp_pass = (((dut_resp ^ mem_ans[idx_q]) & mask_q) == '0);
    last_vec = (CW'(idx_q) == (n_q - CW'(1)));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          n_d        = n_start;
          mask_d     = cmp_mask;
          score_d    = '0;
          err_d      = '0;
          ferr_idx_d = '0;
          ferr_vld_d = 1'b0;
          idx_d      = '0;
          state_d    = (n_start == '0) ? S_DONE : S_APPLY;
        end
      end
      S_APPLY: begin
        stim_d  = mem_stim[idx_q];
        wcnt_d  = LCW'(LAT);
        state_d = (LAT == 0) ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - LCW'(1);
        if (wcnt_q == LCW'(1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cmp_pass) begin
          score_d = score_q + CW'(1);
        end else begin
          err_d = err_q + CW'(1);
          if (!ferr_vld_q) begin
            ferr_idx_d = idx_q;
            ferr_vld_d = 1'b1;
          end
        end
        if (last_vec) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags follow the state being entered so they stay registered
    busy_d = (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  assign dut_stim      = stim_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign score         = score_q;
  assign err_count     = err_q;
  assign first_err_idx = ferr_idx_q;
  assign first_err_vld = ferr_vld_q;

endmodule

// File: tb/tb_vector_check_engine.sv
// Directed bench: three engines (combinational ALU, 3-stage pipe at LAT=3 and LAT=2),
// expected run results queued at start and checked when done rises.
module tb_vector_check_engine;

  localparam int unsigned NI = 3;

  logic        clk;
  logic        rst;
  logic        start [NI];
  logic        ld_en [NI];
  logic [3:0]  ld_addr;
  logic [67:0] ld_stim;
  logic [33:0] ld_ans;
  logic [4:0]  num_tests;
  logic [33:0] cmp_mask;

  logic [67:0] stim_o  [NI];
  logic        busy_o  [NI];
  logic        done_o  [NI];
  logic [4:0]  score_o [NI];
  logic [4:0]  err_o   [NI];
  logic [3:0]  fidx_o  [NI];
  logic        fvld_o  [NI];

  logic [33:0] resp_alu;
  logic [33:0] p3_r1, p3_r2, p3_r3;
  logic [33:0] p2_r1, p2_r2, p2_r3;

  typedef struct {
    int score;
    int err;
    int fidx;
    int fvld;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vector_check_engine #(.LAT(0)) u_alu (
    .clk(clk), .rst(rst), .ld_en(ld_en[0]), .ld_addr(ld_addr), .ld_stim(ld_stim),
    .ld_ans(ld_ans), .num_tests(num_tests), .cmp_mask(cmp_mask), .start(start[0]),
    .dut_stim(stim_o[0]), .dut_resp(resp_alu), .busy(busy_o[0]), .done(done_o[0]),
    .score(score_o[0]), .err_count(err_o[0]), .first_err_idx(fidx_o[0]),
    .first_err_vld(fvld_o[0])
  );

  vector_check_engine #(.LAT(3)) u_p3 (
    .clk(clk), .rst(rst), .ld_en(ld_en[1]), .ld_addr(ld_addr), .ld_stim(ld_stim),
    .ld_ans(ld_ans), .num_tests(num_tests), .cmp_mask(cmp_mask), .start(start[1]),
    .dut_stim(stim_o[1]), .dut_resp(p3_r3), .busy(busy_o[1]), .done(done_o[1]),
    .score(score_o[1]), .err_count(err_o[1]), .first_err_idx(fidx_o[1]),
    .first_err_vld(fvld_o[1])
  );

  vector_check_engine #(.LAT(2)) u_p2 (
    .clk(clk), .rst(rst), .ld_en(ld_en[2]), .ld_addr(ld_addr), .ld_stim(ld_stim),
    .ld_ans(ld_ans), .num_tests(num_tests), .cmp_mask(cmp_mask), .start(start[2]),
    .dut_stim(stim_o[2]), .dut_resp(p2_r3), .busy(busy_o[2]), .done(done_o[2]),
    .score(score_o[2]), .err_count(err_o[2]), .first_err_idx(fidx_o[2]),
    .first_err_vld(fvld_o[2])
  );

  // Reference ALU: {invA, invB, op, src1, src2} -> {overflow, zero, result}
  function automatic logic [33:0] alu(input logic [67:0] s);
    logic [31:0] a, b, r;
    logic        ov;
    a  = s[67] ? ~s[63:32] : s[63:32];
    b  = s[66] ? ~s[31:0]  : s[31:0];
    ov = 1'b0;
    case (s[65:64])
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: begin
        r  = a + b + {31'b0, s[66]};
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      default: r = a ^ b;
    endcase
    return {ov, (r == 32'h0), r};
  endfunction

  always_comb resp_alu = alu(stim_o[0]);

  // Pass-through DUT as a 3-register pipe
  always @(posedge clk) begin
    if (rst) begin
      p3_r1 <= '0; p3_r2 <= '0; p3_r3 <= '0;
      p2_r1 <= '0; p2_r2 <= '0; p2_r3 <= '0;
    end else begin
      p3_r1 <= stim_o[1][33:0]; p3_r2 <= p3_r1; p3_r3 <= p3_r2;
      p2_r1 <= stim_o[2][33:0]; p2_r2 <= p2_r1; p2_r3 <= p2_r2;
    end
  end

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] sel, input int a, input logic [67:0] s,
                      input logic [33:0] an);
    ld_addr = 4'(a);
    ld_stim = s;
    ld_ans  = an;
    for (int i = 0; i < NI; i++) ld_en[i] = sel[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) ld_en[i] = 1'b0;
  endtask

  task automatic run(input int i, input int n, input logic [33:0] mask,
                     input int es, input int ee, input int ef, input int ev,
                     input int ec, input bit disturb);
    exp_t e;
    int   cyc;
    bit   saw_busy;
    sb.push_back('{score: es, err: ee, fidx: ef, fvld: ev, cyc: ec});
    num_tests = 5'(n);
    cmp_mask  = mask;
    start[i]  = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    cyc      = 0;
    saw_busy = busy_o[i];
    while (done_o[i] !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy_o[i]) saw_busy = 1'b1;
      if (disturb && cyc == 10) begin
        start[i] = 1'b1;
        ld_en[i] = 1'b1;
        ld_addr  = 4'd5;
        ld_stim  = '0;
        ld_ans   = 34'h3_DEAD_BEEF;
      end else begin
        start[i] = 1'b0;
        ld_en[i] = 1'b0;
      end
    end
    e = sb.pop_front();
    check($sformatf("inst%0d n%0d done", i, n), 68'(done_o[i]), 68'(1));
    check($sformatf("inst%0d n%0d cycles", i, n), 68'(cyc), 68'(e.cyc));
    check($sformatf("inst%0d n%0d busy_seen", i, n), 68'(saw_busy), 68'(n > 0));
    check($sformatf("inst%0d n%0d score", i, n), 68'(score_o[i]), 68'(e.score));
    check($sformatf("inst%0d n%0d err_count", i, n), 68'(err_o[i]), 68'(e.err));
    check($sformatf("inst%0d n%0d first_err_idx", i, n), 68'(fidx_o[i]), 68'(e.fidx));
    check($sformatf("inst%0d n%0d first_err_vld", i, n), 68'(fvld_o[i]), 68'(e.fvld));
    check($sformatf("inst%0d n%0d total", i, n), 68'(int'(score_o[i]) + int'(err_o[i])),
          68'(e.score + e.err));
  endtask

  logic [67:0] alu_stim [4];
  logic [33:0] alu_ans  [4];

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    ld_addr   = '0;
    ld_stim   = '0;
    ld_ans    = '0;
    num_tests = '0;
    cmp_mask  = '0;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      ld_en[i] = 1'b0;
    end

    alu_stim[0] = {1'b0, 1'b0, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F};
    alu_stim[1] = {1'b0, 1'b0, 2'b01, 32'h0000_0000, 32'h0000_0000};
    alu_stim[2] = {1'b0, 1'b0, 2'b10, 32'h7FFF_FFFF, 32'h0000_0001};
    alu_stim[3] = {1'b0, 1'b1, 2'b10, 32'h0000_0005, 32'h0000_0005};
    alu_ans[0]  = 34'h0_0F0F_0000;
    alu_ans[1]  = 34'h1_0000_0000;
    alu_ans[2]  = 34'h2_8000_0000;
    alu_ans[3]  = 34'h1_0000_0000;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset inst%0d busy", i), 68'(busy_o[i]), 68'(0));
      check($sformatf("reset inst%0d done", i), 68'(done_o[i]), 68'(0));
      check($sformatf("reset inst%0d score", i), 68'(score_o[i]), 68'(0));
      check($sformatf("reset inst%0d dut_stim", i), stim_o[i], 68'(0));
    end
    rst = 1'b0;

    for (int a = 0; a < 4; a++) load(3'b001, a, alu_stim[a], alu_ans[a]);
    for (int a = 0; a < 16; a++)
      load(3'b110, a, {34'(a), 34'h1_2345_0000 + 34'(a)}, 34'h1_2345_0000 + 34'(a));

    // Combinational ALU, all answers correct
    run(0, 4, 34'h3_FFFF_FFFF, 4, 0, 0, 0, 8, 1'b0);
    check("alu dut_stim holds last", stim_o[0], alu_stim[3]);

    // Corrupted zero flag on vector 2, then masked out
    load(3'b001, 2, alu_stim[2], alu_ans[2] ^ 34'h1_0000_0000);
    run(0, 4, 34'h3_FFFF_FFFF, 3, 1, 2, 1, 8, 1'b0);
    run(0, 4, 34'h2_FFFF_FFFF, 4, 0, 0, 0, 8, 1'b0);

    // Latency-matched and latency-short runs against the 3-stage pipe
    run(1, 16, 34'h3_FFFF_FFFF, 16, 0, 0, 0, 80, 1'b0);
    run(2, 16, 34'h3_FFFF_FFFF, 0, 16, 0, 1, 64, 1'b0);

    // Empty run and oversize request
    run(1, 0, 34'h3_FFFF_FFFF, 0, 0, 0, 0, 0, 1'b0);
    run(1, 20, 34'h3_FFFF_FFFF, 16, 0, 0, 0, 80, 1'b0);

    // Start and memory write while busy must be ignored
    run(1, 16, 34'h3_FFFF_FFFF, 16, 0, 0, 0, 80, 1'b1);
    run(1, 16, 34'h3_FFFF_FFFF, 16, 0, 0, 0, 80, 1'b0);

    // Reset mid-run, then rerun with memory intact
    load(3'b001, 2, alu_stim[2], alu_ans[2]);
    num_tests = 5'd4;
    cmp_mask  = 34'h3_FFFF_FFFF;
    start[0]  = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre-reset partial score", 68'(score_o[0]), 68'(2));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort busy", 68'(busy_o[0]), 68'(0));
    check("abort done", 68'(done_o[0]), 68'(0));
    check("abort score", 68'(score_o[0]), 68'(0));
    check("abort dut_stim", stim_o[0], 68'(0));
    run(0, 4, 34'h3_FFFF_FFFF, 4, 0, 0, 0, 8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
